// File: rtl/ssr_pkg.sv
// Shared definitions for the parametrised security controller: state encoding,
// zone indices and default zone masks.
package ssr_pkg;

  localparam int ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    ALARME    = 3'd4
  } estado_t;

  localparam int ZONA_I  = 0;
  localparam int ZONA_P  = 1;
  localparam int ZONA_J1 = 2;
  localparam int ZONA_J2 = 3;
  localparam int ZONA_J3 = 4;
  localparam int ZONA_J4 = 5;

  localparam logic [31:0] MASCARA_JANELAS_PADRAO =
    32'((1 << ZONA_J1) | (1 << ZONA_J2) | (1 << ZONA_J3) | (1 << ZONA_J4));
  localparam logic [31:0] MASCARA_Y1_PADRAO       = MASCARA_JANELAS_PADRAO | 32'(1 << ZONA_P);
  localparam logic [31:0] MASCARA_Y0_PADRAO       = 32'(1 << ZONA_I);
  localparam logic [31:0] MASCARA_IMEDIATA_PADRAO = MASCARA_JANELAS_PADRAO;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ssr_parametrizado_contador_atraso.sv
// Loadable down-counter shared by the exit and entry delays; load wins over
// decrement, and the caller decides when decrementing is legal.
module contador_atraso #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_carregar,
  input  logic [W-1:0] i_valor_carga,
  input  logic         i_habilitar,
  output logic [W-1:0] o_valor,
  output logic         o_zero
);

  logic [W-1:0] r_valor;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valor <= '0;
    end else if (i_carregar) begin
      r_valor <= i_valor_carga;
    end else if (i_habilitar) begin
      r_valor <= r_valor - 1'b1;
    end
  end

  assign o_valor = r_valor;
  assign o_zero  = (r_valor == '0);

endmodule

// File: rtl/ssr_parametrizado.sv
// Residential security controller: password arm/disarm, exit/entry delays,
// latched alarm with pulsed siren, sticky zone log and wrong-password lockout.
module ssr_parametrizado
  import ssr_pkg::*;
#(
  parameter int          N_ZONAS          = 6,
  parameter int          SENHA_W          = 4,
  parameter logic [31:0] MASCARA_Y1       = MASCARA_Y1_PADRAO,
  parameter logic [31:0] MASCARA_Y0       = MASCARA_Y0_PADRAO,
  parameter logic [31:0] MASCARA_IMEDIATA = MASCARA_IMEDIATA_PADRAO,
  parameter int          ATRASO_SAIDA     = 16,
  parameter int          ATRASO_ENTRADA   = 16,
  parameter int          MAX_TENTATIVAS   = 3,
  parameter int          DIV_SIRENE       = 4
) (
  input  logic                                gerador_frequencia,
  input  logic                                reset,
  input  logic [N_ZONAS-1:0]                  zonas,
  input  logic                                y,
  input  logic [SENHA_W-1:0]                  senha_sistema,
  input  logic [SENHA_W-1:0]                  senha_usuario,
  input  logic                                tecla_ok,
  output logic                                alarme,
  output logic                                sirene,
  output logic                                armado,
  output logic [ESTADO_W-1:0]                 estado,
  output logic [N_ZONAS-1:0]                  zona_violada,
  output logic [$clog2(MAX_TENTATIVAS+1)-1:0] tentativas
);

  localparam int TIMER_W = max_int(1, $clog2(max_int(ATRASO_SAIDA, ATRASO_ENTRADA)));
  localparam int TENT_W  = $clog2(MAX_TENTATIVAS + 1);
  localparam int DIV_W   = max_int(1, $clog2(DIV_SIRENE));

  localparam logic [N_ZONAS-1:0] MASC_Y1  = N_ZONAS'(MASCARA_Y1);
  localparam logic [N_ZONAS-1:0] MASC_Y0  = N_ZONAS'(MASCARA_Y0);
  localparam logic [N_ZONAS-1:0] MASC_IMD = N_ZONAS'(MASCARA_IMEDIATA);

  estado_t             r_estado;
  logic [N_ZONAS-1:0]  r_mascara;
  logic [N_ZONAS-1:0]  r_zona_violada;
  logic [TENT_W-1:0]   r_tentativas;
  logic                r_alarme;
  logic                r_armado;
  logic                r_sirene;
  logic [DIV_W-1:0]    r_div;

  estado_t             w_prox;
  logic                w_ok;
  logic                w_erro;
  logic                w_bloqueio;
  logic [N_ZONAS-1:0]  w_viol;
  logic                w_viol_imediata;
  logic                w_viol_atrasada;
  logic [TENT_W-1:0]   w_tent_prox;
  logic                w_entra_saida;
  logic                w_monitorando;
  logic                w_carregar;
  logic                w_decrementar;
  logic [TIMER_W-1:0]  w_valor_carga;
  logic [TIMER_W-1:0]  w_timer;
  logic                w_timer_zero;

  assign w_ok            = tecla_ok && (senha_usuario == senha_sistema);
  assign w_erro          = tecla_ok && !w_ok;
  assign w_bloqueio      = w_erro && (r_tentativas >= TENT_W'(MAX_TENTATIVAS - 1));
  assign w_viol          = zonas & r_mascara;
  assign w_viol_imediata = |(w_viol & MASC_IMD);
  assign w_viol_atrasada = |w_viol;
  assign w_monitorando   = (r_estado == ARMADO) || (r_estado == ENTRADA) || (r_estado == ALARME);
  assign w_entra_saida   = (r_estado == DESARMADO) && (w_prox == SAIDA);

  // Priority: ok > lockout > instant zone > timer expiry / delayed zone.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_prox = r_estado;
    if (w_ok) begin
      w_prox = (r_estado == DESARMADO) ? SAIDA : DESARMADO;
    end else if (w_bloqueio) begin
      w_prox = ALARME;
    end else begin
      case (r_estado)
        DESARMADO: w_prox = DESARMADO;
        SAIDA:     if (w_timer_zero) w_prox = ARMADO;
        ARMADO: begin
          if (w_viol_imediata)      w_prox = ALARME;
          else if (w_viol_atrasada) w_prox = ENTRADA;
        end
        ENTRADA:   if (w_viol_imediata || w_timer_zero) w_prox = ALARME;
        ALARME:    w_prox = ALARME;
        default:   w_prox = DESARMADO;
      endcase
    end
  end

  always_comb begin
    w_tent_prox = r_tentativas;
    if (w_ok) begin
      w_tent_prox = '0;
    end else if (w_erro && (r_tentativas != TENT_W'(MAX_TENTATIVAS))) begin
      w_tent_prox = r_tentativas + 1'b1;
    end
  end

  assign w_carregar    = w_entra_saida || ((r_estado == ARMADO) && (w_prox == ENTRADA));
  assign w_valor_carga = (r_estado == DESARMADO) ? TIMER_W'(ATRASO_SAIDA - 1)
                                                 : TIMER_W'(ATRASO_ENTRADA - 1);
  assign w_decrementar = ((r_estado == SAIDA) || (r_estado == ENTRADA)) &&
                         (w_prox == r_estado) && (w_timer != '0);

  contador_atraso #(
    .W (TIMER_W)
  ) u_contador_atraso (
    .i_clk         (gerador_frequencia),
    .i_rst         (reset),
    .i_carregar    (w_carregar),
    .i_valor_carga (w_valor_carga),
    .i_habilitar   (w_decrementar),
    .o_valor       (w_timer),
    .o_zero        (w_timer_zero)
  );

  always_ff @(posedge gerador_frequencia) begin
    if (reset) begin
      r_estado       <= DESARMADO;
      r_mascara      <= '0;
      r_zona_violada <= '0;
      r_tentativas   <= '0;
      r_alarme       <= 1'b0;
      r_armado       <= 1'b0;
      r_sirene       <= 1'b0;
      r_div          <= '0;
    end else begin
      r_estado     <= w_prox;
      r_tentativas <= w_tent_prox;
      r_alarme     <= (w_prox == ALARME);
      r_armado     <= (w_prox == ARMADO) || (w_prox == ENTRADA);

      // The mode is captured only here; y is ignored everywhere else.
      if (w_entra_saida) begin
        r_mascara      <= y ? MASC_Y1 : MASC_Y0;
        r_zona_violada <= '0;
      end else if (w_monitorando) begin
        r_zona_violada <= r_zona_violada | w_viol;
      end

      // Siren starts high on alarm entry and toggles every DIV_SIRENE cycles.
      if (w_prox != ALARME) begin
        r_sirene <= 1'b0;
        r_div    <= '0;
      end else if (r_estado != ALARME) begin
        r_sirene <= 1'b1;
        r_div    <= '0;
      end else if (r_div == DIV_W'(DIV_SIRENE - 1)) begin
        r_sirene <= ~r_sirene;
        r_div    <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign estado       = r_estado;
  assign alarme       = r_alarme;
  assign sirene       = r_sirene;
  assign armado       = r_armado;
  assign zona_violada = r_zona_violada;
  assign tentativas   = r_tentativas;

endmodule

// File: tb/tb_ssr_parametrizado.sv
// Scoreboard bench: a cycle model pushes expected outputs when inputs are
// driven; they are popped and compared one edge later.
module tb_ssr_parametrizado;
  import ssr_pkg::*;

  localparam int         AS    = 16;
  localparam int         AE    = 16;
  localparam int         MAXT  = 3;
  localparam int         DIV   = 4;
  localparam logic [5:0] M_Y1  = 6'b111110;
  localparam logic [5:0] M_Y0  = 6'b000001;
  localparam logic [5:0] M_IM  = 6'b111100;
  localparam logic [3:0] SENHA = 4'hA;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] zonas;
  logic       y;
  logic [3:0] senha_sis;
  logic [3:0] senha_usr;
  logic       tecla_ok;
  logic       alarme, sirene, armado;
  logic [2:0] estado;
  logic [5:0] zona_violada;
  logic [1:0] tentativas;

  always #5 clk = ~clk;

  ssr_parametrizado dut (
    .gerador_frequencia (clk),
    .reset              (rst),
    .zonas              (zonas),
    .y                  (y),
    .senha_sistema      (senha_sis),
    .senha_usuario      (senha_usr),
    .tecla_ok           (tecla_ok),
    .alarme             (alarme),
    .sirene             (sirene),
    .armado             (armado),
    .estado             (estado),
    .zona_violada       (zona_violada),
    .tentativas         (tentativas)
  );

  typedef struct packed {
    logic [2:0] estado;
    logic       alarme;
    logic       sirene;
    logic       armado;
    logic [5:0] zv;
    logic [1:0] tent;
  } esperado_t;

  esperado_t fila[$];
  int n_checks = 0;
  int n_fail   = 0;

  int         m_est, m_cnt, m_alarm_cnt, m_tent;
  logic [5:0] m_mask, m_zv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: obtido=%0h esperado=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycle model: delays count up from 0, siren derived from cycles spent in alarm.
  task automatic modelo();
    bit         ok, erro, lock;
    logic [5:0] viol;
    int         prox;
    esperado_t  e;
    if (rst) begin
      m_est = 0; m_cnt = 0; m_alarm_cnt = 0; m_tent = 0; m_mask = '0; m_zv = '0;
    end else begin
      ok   = tecla_ok && (senha_usr == senha_sis);
      erro = tecla_ok && !ok;
      viol = zonas & m_mask;
      lock = erro && (m_tent + 1 >= MAXT);
      if (m_est >= 2) m_zv = m_zv | viol;
      prox = m_est;
      if (ok) begin
        if (m_est == 0) begin
          prox = 1; m_mask = y ? M_Y1 : M_Y0; m_cnt = 0; m_zv = '0;
        end else begin
          prox = 0;
        end
      end else if (lock) begin
        prox = 4;
      end else begin
        case (m_est)
          1: if (m_cnt == AS - 1) prox = 2; else m_cnt++;
          2: if ((viol & M_IM) != 0) prox = 4;
             else if (viol != 0) begin prox = 3; m_cnt = 0; end
          3: if ((viol & M_IM) != 0 || m_cnt == AE - 1) prox = 4; else m_cnt++;
          default: ;
        endcase
      end
      if (ok) m_tent = 0;
      else if (erro && m_tent < MAXT) m_tent++;
      if (prox == 4) m_alarm_cnt = (m_est == 4) ? m_alarm_cnt + 1 : 0;
      m_est = prox;
    end
    e.estado = 3'(m_est);
    e.alarme = (m_est == 4);
    e.armado = (m_est == 2) || (m_est == 3);
    e.sirene = (m_est == 4) && (((m_alarm_cnt / DIV) % 2) == 0);
    e.zv     = m_zv;
    e.tent   = 2'(m_tent);
    fila.push_back(e);
  endtask

  task automatic ciclo();
    esperado_t e;
    modelo();
    @(posedge clk);
    #1;
    e = fila.pop_front();
    check("estado", estado, e.estado);
    check("alarme", alarme, e.alarme);
    check("sirene", sirene, e.sirene);
    check("armado", armado, e.armado);
    check("zona_violada", zona_violada, e.zv);
    check("tentativas", tentativas, e.tent);
    tecla_ok = 1'b0;
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  task automatic tecla(input logic [3:0] s);
    senha_usr = s;
    tecla_ok  = 1'b1;
    ciclo();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: tempo de simulacao esgotado");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; zonas = '0; y = 1'b1; senha_sis = SENHA; senha_usr = '0; tecla_ok = 1'b0;
    ciclos(2);
    rst = 1'b0;
    check("reset_estado", estado, 0);
    check("reset_saidas", {alarme, sirene, armado, zona_violada, tentativas}, 0);

    // 1: exit delay, delayed door zone, entry delay expiry, siren cadence.
    y = 1'b1;
    tecla(SENHA);
    check("t1_saida", estado, 1);
    ciclos(15);
    check("t1_saida_fim", estado, 1);
    ciclo();
    check("t1_armado", estado, 2);
    check("t1_armado_flag", armado, 1);
    zonas = 6'b000010;
    ciclo();
    check("t1_entrada", estado, 3);
    ciclos(15);
    check("t1_entrada_fim", estado, 3);
    ciclo();
    check("t1_alarme", estado, 4);
    check("t1_sirene_on", sirene, 1);
    ciclos(3);
    check("t1_sirene_still", sirene, 1);
    ciclo();
    check("t1_sirene_off", sirene, 0);
    ciclos(4);
    check("t1_sirene_back", sirene, 1);
    check("t1_zv", zona_violada, 6'b000010);
    zonas = '0;
    ciclos(3);
    check("t1_latched", estado, 4);
    tecla(SENHA);
    check("t1_desarmado", estado, 0);

    // 2: instant window zone, then disarm from alarm.
    tecla(SENHA);
    ciclos(16);
    check("t2_armado", estado, 2);
    zonas = 6'b001000;
    ciclo();
    check("t2_imediato", estado, 4);
    zonas = '0;
    tecla(SENHA);
    check("t2_off", {estado, alarme, sirene}, 0);

    // 3: home mode ignores perimeter, internal sensor starts entry delay.
    y = 1'b0;
    tecla(SENHA);
    ciclos(16);
    zonas = 6'b111110;
    ciclos(3);
    check("t3_ignora", estado, 2);
    zonas = 6'b111111;
    ciclo();
    check("t3_entrada", estado, 3);
    ciclos(3);
    tecla(SENHA);
    check("t3_desarma", estado, 0);
    check("t3_zv", zona_violada, 6'b000001);
    zonas = '0;

    // 4: wrong-password lockout from DESARMADO.
    tecla(4'h5);
    check("t4_tent1", tentativas, 1);
    tecla(4'h5);
    check("t4_tent2", tentativas, 2);
    check("t4_ainda0", estado, 0);
    tecla(4'h5);
    check("t4_tent3", tentativas, 3);
    check("t4_tamper", estado, 4);
    tecla(SENHA);
    check("t4_limpa", {estado, tentativas}, 0);

    // 5: abort during SAIDA; y toggled while armed has no effect.
    y = 1'b1;
    tecla(SENHA);
    zonas = 6'b111111;
    ciclo();
    tecla(SENHA);
    check("t5_abort", estado, 0);
    check("t5_zv", zona_violada, 0);
    zonas = '0; y = 1'b0;
    tecla(SENHA);
    ciclos(16);
    y = 1'b1; zonas = 6'b111110;
    ciclos(3);
    check("t5_modo_fixo", estado, 2);
    zonas = '0;
    tecla(SENHA);

    // 6: reset during alarm; ok beats instant zone in ENTRADA.
    y = 1'b1;
    tecla(SENHA);
    ciclos(16);
    zonas = 6'b000100;
    ciclo();
    ciclos(2);
    rst = 1'b1;
    ciclo();
    rst = 1'b0;
    check("t6_reset", {estado, alarme, sirene, armado, zona_violada, tentativas}, 0);
    zonas = '0;
    tecla(SENHA);
    ciclos(16);
    zonas = 6'b000010;
    ciclo();
    check("t6_entrada", estado, 3);
    ciclos(2);
    zonas = 6'b000110;
    tecla(SENHA);
    check("t6_ok_vence", estado, 0);
    zonas = '0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      zonas     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      y         = 1'($urandom);
      senha_usr = ($urandom_range(0, 2) != 0) ? SENHA : 4'($urandom);
      tecla_ok  = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      ciclo();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
